// File: rtl/ctrl_reg_arbiter_if.sv
// Request/grant bus between the requesters and the shared control register.
// The master side drives requests and write data; the slave side is the arbiter.
interface ctrl_reg_arbiter_if;
   logic [3:0]  req;
   logic [31:0] wr_data;
   logic [31:0] wr_mask;
   logic [3:0]  grant;
   logic        ack;
   logic        busy;
   logic        timeout;
   logic [7:0]  control;

   modport master (
      output req, wr_data, wr_mask,
      input  grant, ack, busy, timeout, control
   );

   modport slave (
      input  req, wr_data, wr_mask,
      output grant, ack, busy, timeout, control
   );
endinterface

// File: rtl/ctrl_reg_arbiter.sv
// Round-robin arbiter that applies masked writes from up to four requesters
// to one 8-bit control register, with self-clearing pulse bits and a release timeout.
module ctrl_reg_arbiter #(
   parameter int          NumRequesters = 4,
   parameter logic [7:0]  BitValue      = 8'h00,
   parameter logic [7:0]  PulseMask     = 8'h00,
   parameter logic [7:0]  TimeoutCycles = 8'd255
) (
   input  logic               clock,
   input  logic               reset,
   ctrl_reg_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

   localparam logic [3:0] ActiveMask = 4'((5'b00001 << NumRequesters) - 5'd1);

   state_t      state, state_next;
   logic [3:0]  grant_q, grant_next;
   logic [1:0]  ptr, ptr_next;
   logic [3:0]  lockout, lockout_next;
   logic [7:0]  count, count_next;
   logic        ack_q, ack_next;
   logic        timeout_q, timeout_next;
   logic [7:0]  held, held_next;
   logic [7:0]  pulse, pulse_next;

   logic [3:0]  eligible;
   logic [1:0]  winner;
   logic [1:0]  cand;
   logic        found;
   logic [7:0]  wr_d;
   logic [7:0]  wr_m;

   assign eligible = bus.req & ActiveMask & ~lockout;
   assign wr_d     = bus.wr_data[{ptr, 3'b000} +: 8];
   assign wr_m     = bus.wr_mask[{ptr, 3'b000} +: 8];

   // Search upward from the last winner so every active requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      cand   = ptr;
      for (int k = 1; k <= NumRequesters; k++) begin
         cand = 2'((int'(ptr) + k) % NumRequesters);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_next   = state;
      grant_next   = grant_q;
      ptr_next     = ptr;
      lockout_next = lockout & bus.req;
      count_next   = count;
      ack_next     = ack_q;
      timeout_next = 1'b0;
      held_next    = held;
      pulse_next   = '0;

      case (state)
         IDLE: begin
            if (found) begin
               grant_next = 4'b0001 << winner;
               ptr_next   = winner;
               state_next = WRITE;
            end
         end
         WRITE: begin
            held_next  = (held & ~(wr_m & ~PulseMask)) | (wr_d & wr_m & ~PulseMask);
            pulse_next = wr_d & wr_m & PulseMask;
            ack_next   = 1'b1;
            count_next = '0;
            state_next = RELEASE;
         end
         RELEASE: begin
            if (!bus.req[ptr]) begin
               state_next = IDLE;
               ack_next   = 1'b0;
               grant_next = '0;
            end else if (TimeoutCycles != 8'd0 && count == TimeoutCycles - 8'd1) begin
               // A stuck requester is locked out until it drops req once.
               state_next        = IDLE;
               ack_next          = 1'b0;
               grant_next        = '0;
               timeout_next      = 1'b1;
               lockout_next[ptr] = 1'b1;
            end else begin
               count_next = count + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         grant_q   <= '0;
         ptr       <= 2'(NumRequesters - 1);
         lockout   <= '0;
         count     <= '0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         held      <= BitValue & ~PulseMask;
         pulse     <= '0;
      end else begin
         state     <= state_next;
         grant_q   <= grant_next;
         ptr       <= ptr_next;
         lockout   <= lockout_next;
         count     <= count_next;
         ack_q     <= ack_next;
         timeout_q <= timeout_next;
         held      <= held_next;
         pulse     <= pulse_next;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.ack     = ack_q;
   assign bus.busy    = (state != IDLE);
   assign bus.timeout = timeout_q;
   assign bus.control = held | pulse;

endmodule

// File: tb/tb_ctrl_reg_arbiter.sv
// Directed bench for two differently parameterised arbiters, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_ctrl_reg_arbiter;

   logic clock;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst_v [2];
   logic [3:0]  req_v [2];
   logic [31:0] dat_v [2];
   logic [31:0] msk_v [2];

   ctrl_reg_arbiter_if bus_a ();
   ctrl_reg_arbiter_if bus_b ();

   assign bus_a.req     = req_v[0];
   assign bus_a.wr_data = dat_v[0];
   assign bus_a.wr_mask = msk_v[0];
   assign bus_b.req     = req_v[1];
   assign bus_b.wr_data = dat_v[1];
   assign bus_b.wr_mask = msk_v[1];

   ctrl_reg_arbiter #(
      .NumRequesters (4),
      .BitValue      (8'hA5),
      .PulseMask     (8'h0F),
      .TimeoutCycles (8'd4)
   ) dut_a (
      .clock (clock),
      .reset (rst_v[0]),
      .bus   (bus_a)
   );

   ctrl_reg_arbiter #(
      .NumRequesters (3),
      .BitValue      (8'h00),
      .PulseMask     (8'h00),
      .TimeoutCycles (8'd0)
   ) dut_b (
      .clock (clock),
      .reset (rst_v[1]),
      .bus   (bus_b)
   );

   logic [3:0] act_grant [2];
   logic       act_ack   [2];
   logic       act_busy  [2];
   logic       act_to    [2];
   logic [7:0] act_ctrl  [2];

   assign act_grant[0] = bus_a.grant;
   assign act_ack[0]   = bus_a.ack;
   assign act_busy[0]  = bus_a.busy;
   assign act_to[0]    = bus_a.timeout;
   assign act_ctrl[0]  = bus_a.control;
   assign act_grant[1] = bus_b.grant;
   assign act_ack[1]   = bus_b.ack;
   assign act_busy[1]  = bus_b.busy;
   assign act_to[1]    = bus_b.timeout;
   assign act_ctrl[1]  = bus_b.control;

   function automatic int nr_of(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic logic [7:0] bv_of(input int k);
      return (k == 0) ? 8'hA5 : 8'h00;
   endfunction

   function automatic logic [7:0] pm_of(input int k);
      return (k == 0) ? 8'h0F : 8'h00;
   endfunction

   function automatic int to_of(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   // Transaction view: who owns the register and how many edges since the grant.
   typedef struct {
      int         owner;
      int         age;
      int         last;
      logic [3:0] lock;
      logic [7:0] held;
      logic [7:0] pulse;
      logic       to;
   } model_t;

   model_t mdl    [2];
   bit     mvalid [2];

   function automatic model_t model_step(input model_t s, input int k, input logic rst,
                                         input logic [3:0] r, input logic [31:0] d,
                                         input logic [31:0] m);
      model_t     n;
      int         c;
      logic [7:0] dd, mm, pm;
      n  = s;
      pm = pm_of(k);
      if (rst) begin
         n.owner = -1;
         n.age   = 0;
         n.last  = nr_of(k) - 1;
         n.lock  = '0;
         n.held  = bv_of(k) & ~pm;
         n.pulse = '0;
         n.to    = 1'b0;
         return n;
      end
      n.lock  = s.lock & r;
      n.pulse = '0;
      n.to    = 1'b0;
      if (s.owner < 0) begin
         for (int i = 1; i <= nr_of(k); i++) begin
            c = (s.last + i) % nr_of(k);
            if (n.owner < 0 && r[2'(c)] && !s.lock[2'(c)]) begin
               n.owner = c;
               n.age   = 0;
               n.last  = c;
            end
         end
      end else if (s.age == 0) begin
         dd      = 8'(d >> (8 * s.owner));
         mm      = 8'(m >> (8 * s.owner));
         n.held  = (s.held & ~(mm & ~pm)) | (dd & mm & ~pm);
         n.pulse = dd & mm & pm;
         n.age   = 1;
      end else if (!r[2'(s.owner)]) begin
         n.owner = -1;
      end else if (to_of(k) != 0 && s.age == to_of(k)) begin
         n.owner              = -1;
         n.to                 = 1'b1;
         n.lock[2'(s.owner)]  = 1'b1;
      end else begin
         n.age = s.age + 1;
      end
      return n;
   endfunction

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         mdl[k] <= model_step(mdl[k], k, rst_v[k], req_v[k], dat_v[k], msk_v[k]);
         if (rst_v[k]) mvalid[k] <= 1'b1;
      end
   end

   int vec_count  = 0;
   int miss_count = 0;

   int         pin_seq = 0;
   int         pin_k;
   string      pin_name;
   logic [3:0] pin_grant;
   logic       pin_ack;
   logic       pin_busy;
   logic [7:0] pin_ctrl;
   logic       pin_to;

   int         pin_seen = 0;
   logic [3:0] exp_grant;
   logic       exp_ack;
   logic       exp_busy;
   logic [7:0] exp_ctrl;

   // Single checker: model against both DUTs every cycle, then any pinned literal.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (mvalid[k]) begin
               exp_grant = (mdl[k].owner >= 0) ? 4'(1 << mdl[k].owner) : 4'b0000;
               exp_ack   = (mdl[k].owner >= 0) && (mdl[k].age >= 1);
               exp_busy  = (mdl[k].owner >= 0);
               exp_ctrl  = mdl[k].held | mdl[k].pulse;
               vec_count++;
               if (act_grant[k] !== exp_grant || act_ack[k] !== exp_ack ||
                   act_busy[k] !== exp_busy || act_to[k] !== mdl[k].to ||
                   act_ctrl[k] !== exp_ctrl) begin
                  miss_count++;
                  $display("[TB] FAIL model_%0d t=%0t: got grant=%b ack=%b busy=%b timeout=%b control=%h, expected grant=%b ack=%b busy=%b timeout=%b control=%h",
                           k, $time, act_grant[k], act_ack[k], act_busy[k], act_to[k], act_ctrl[k],
                           exp_grant, exp_ack, exp_busy, mdl[k].to, exp_ctrl);
               end
            end
         end
         if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            vec_count++;
            if (act_grant[pin_k] !== pin_grant || act_ack[pin_k] !== pin_ack ||
                act_busy[pin_k] !== pin_busy || act_to[pin_k] !== pin_to ||
                act_ctrl[pin_k] !== pin_ctrl) begin
               miss_count++;
               $display("[TB] FAIL %s t=%0t: got grant=%b ack=%b busy=%b timeout=%b control=%h, expected grant=%b ack=%b busy=%b timeout=%b control=%h",
                        pin_name, $time, act_grant[pin_k], act_ack[pin_k], act_busy[pin_k],
                        act_to[pin_k], act_ctrl[pin_k], pin_grant, pin_ack, pin_busy, pin_to, pin_ctrl);
            end
         end
      end
   end

   task automatic applyStimulus(input int k, input logic rst, input logic [3:0] r,
                                input logic [31:0] d, input logic [31:0] m);
      @(negedge clock);
      rst_v[k] = rst;
      req_v[k] = r;
      dat_v[k] = d;
      msk_v[k] = m;
   endtask

   // Expectation for the outputs right after the next rising edge.
   task automatic checkOutput(input int k, input string name, input logic [3:0] g,
                              input logic a, input logic b, input logic [7:0] c,
                              input logic t);
      pin_k     = k;
      pin_name  = name;
      pin_grant = g;
      pin_ack   = a;
      pin_busy  = b;
      pin_ctrl  = c;
      pin_to    = t;
      pin_seq++;
   endtask

   task automatic runRound(input int k, input int g, input logic [7:0] c);
      logic [3:0] oh;
      oh = 4'(1 << g);
      applyStimulus(k, 1'b0, 4'b1111, 32'h0, 32'h0);
      checkOutput(k, "rr_grant", oh, 1'b0, 1'b1, c, 1'b0);
      applyStimulus(k, 1'b0, 4'b1111, 32'h0, 32'h0);
      checkOutput(k, "rr_ack", oh, 1'b1, 1'b1, c, 1'b0);
      applyStimulus(k, 1'b0, 4'b1111 & ~oh, 32'h0, 32'h0);
      checkOutput(k, "rr_release", 4'b0000, 1'b0, 1'b0, c, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1;
         req_v[k] = '0;
         dat_v[k] = '0;
         msk_v[k] = '0;
      end

      applyStimulus(0, 1'b1, 4'b0000, 32'h0, 32'h0);
      checkOutput(0, "reset_a", 4'b0000, 1'b0, 1'b0, 8'hA0, 1'b0);
      applyStimulus(1, 1'b1, 4'b0000, 32'h0, 32'h0);
      checkOutput(1, "reset_b", 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 4'b0000, 32'h0, 32'h0);

      // Four requesters: 0,1,2,3 then wrap to 0.
      runRound(0, 0, 8'hA0);
      runRound(0, 1, 8'hA0);
      runRound(0, 2, 8'hA0);
      runRound(0, 3, 8'hA0);
      runRound(0, 0, 8'hA0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);

      applyStimulus(1, 1'b0, 4'b0001, 32'h0000_003C, 32'h0000_00F0);
      checkOutput(1, "mw_grant", 4'b0001, 1'b0, 1'b1, 8'h00, 1'b0);
      applyStimulus(1, 1'b0, 4'b0001, 32'h0000_003C, 32'h0000_00F0);
      checkOutput(1, "mw_write", 4'b0001, 1'b1, 1'b1, 8'h30, 1'b0);
      applyStimulus(1, 1'b0, 4'b0001, 32'h0000_003C, 32'h0000_00F0);
      checkOutput(1, "mw_hold", 4'b0001, 1'b1, 1'b1, 8'h30, 1'b0);
      applyStimulus(1, 1'b0, 4'b0000, 32'h0, 32'h0);
      checkOutput(1, "mw_idle", 4'b0000, 1'b0, 1'b0, 8'h30, 1'b0);

      // Three active requesters: req3 is held high but never wins.
      runRound(1, 1, 8'h30);
      runRound(1, 2, 8'h30);
      runRound(1, 0, 8'h30);
      runRound(1, 1, 8'h30);
      applyStimulus(1, 1'b0, 4'b0000, 32'h0, 32'h0);

      applyStimulus(0, 1'b0, 4'b0010, 32'h0000_5100, 32'h0000_F100);
      checkOutput(0, "pl_grant", 4'b0010, 1'b0, 1'b1, 8'hA0, 1'b0);
      applyStimulus(0, 1'b0, 4'b0010, 32'h0000_5100, 32'h0000_F100);
      checkOutput(0, "pl_write", 4'b0010, 1'b1, 1'b1, 8'h51, 1'b0);
      applyStimulus(0, 1'b0, 4'b0010, 32'h0000_5100, 32'h0000_F100);
      checkOutput(0, "pl_clear", 4'b0010, 1'b1, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
      checkOutput(0, "pl_idle", 4'b0000, 1'b0, 1'b0, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0010, 32'h0000_0000, 32'h0000_0100);
      checkOutput(0, "pl_grant2", 4'b0010, 1'b0, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0010, 32'h0000_0000, 32'h0000_0100);
      checkOutput(0, "pl_nopulse", 4'b0010, 1'b1, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);

      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      checkOutput(0, "to_grant", 4'b0100, 1'b0, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      checkOutput(0, "to_ack", 4'b0100, 1'b1, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      checkOutput(0, "to_wait", 4'b0100, 1'b1, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      checkOutput(0, "to_fire", 4'b0000, 1'b0, 1'b0, 8'h50, 1'b1);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      checkOutput(0, "to_next", 4'b0001, 1'b0, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0101, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 4'b0100, 32'h0, 32'h0);
      checkOutput(0, "to_release0", 4'b0000, 1'b0, 1'b0, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0100, 32'h0, 32'h0);
      checkOutput(0, "to_locked", 4'b0000, 1'b0, 1'b0, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 4'b0100, 32'h0, 32'h0);
      checkOutput(0, "to_regrant", 4'b0100, 1'b0, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b0, 4'b0100, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);

      applyStimulus(0, 1'b0, 4'b0001, 32'h0000_00FF, 32'h0000_00FF);
      checkOutput(0, "rst_grant", 4'b0001, 1'b0, 1'b1, 8'h50, 1'b0);
      applyStimulus(0, 1'b1, 4'b0001, 32'h0000_00FF, 32'h0000_00FF);
      checkOutput(0, "rst_mid", 4'b0000, 1'b0, 1'b0, 8'hA0, 1'b0);
      applyStimulus(0, 1'b0, 4'b0001, 32'h0000_00FF, 32'h0000_00FF);
      checkOutput(0, "rst_regrant", 4'b0001, 1'b0, 1'b1, 8'hA0, 1'b0);
      applyStimulus(0, 1'b0, 4'b0001, 32'h0000_00FF, 32'h0000_00FF);
      checkOutput(0, "rst_write", 4'b0001, 1'b1, 1'b1, 8'hFF, 1'b0);
      applyStimulus(0, 1'b0, 4'b0000, 32'h0, 32'h0);
      checkOutput(0, "rst_idle", 4'b0000, 1'b0, 1'b0, 8'hF0, 1'b0);

      repeat (2) @(posedge clock);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
